// File: rtl/accum_sequencer_pkg.sv
// Shared definitions for the accumulating add/sub sequencer: state encoding,
// default sizes, and the index-width helper.
package accum_sequencer_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NOPS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_ACCUM = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Index width; never below one bit, so the counter always exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accum_sequencer_addsub.sv
// Combinational signed adder/subtractor; subtraction adds the inverted
// operand with a carry-in of one.
module addsub_w
    import accum_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff = sub ? ~b : b;
    assign sum     = a + w_b_eff + WIDTH'(sub);

    // Overflow: both addend signs agree but the sum sign differs.
    assign ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/accum_sequencer.sv
// Sequential accumulator: captures NOPS operands plus an add/sub mask, then
// folds them left to right through one shared adder, one operand per cycle.
module accum_sequencer
    import accum_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NOPS  = DEF_NOPS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NOPS*WIDTH-1:0] ops,
    input  logic [NOPS-1:0]       sub_mask,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned     IDX_W    = idx_width(NOPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOPS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NOPS*WIDTH-1:0] r_ops;
    logic [NOPS-1:0]       r_sub_mask;
    logic [IDX_W-1:0]      r_index;
    logic [WIDTH-1:0]      r_result;
    logic                  r_ovf;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [WIDTH-1:0]      w_operand;
    logic                  w_sub;
    logic [WIDTH-1:0]      w_sum;
    logic                  w_step_ovf;

    assign w_last = (r_index == LAST_IDX);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = start ? ST_LOAD : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath controls and next values of the registered status outputs.
    always_comb begin
        w_accept   = 1'b0;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
        w_load     = (r_state == ST_LOAD);
        w_step     = (r_state == ST_ACCUM);
        w_busy_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_ACCUM);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Operand and direction select; the index never exceeds NOPS-1.
    always_comb begin
        w_operand = '0;
        w_sub     = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_operand = r_ops[i*WIDTH +: WIDTH];
                w_sub     = (i != 0) && r_sub_mask[i];
            end
        end
    end

    addsub_w #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (r_result),
        .b   (w_operand),
        .sub (w_sub),
        .sum (w_sum),
        .ovf (w_step_ovf)
    );

    // Capture, load and accumulate; result holds outside LOAD/ACCUM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ops      <= '0;
            r_sub_mask <= '0;
            r_index    <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_ops      <= ops;
                r_sub_mask <= sub_mask;
                r_ovf      <= 1'b0;
                r_index    <= '0;
            end
            if (w_load) begin
                r_result <= r_ops[WIDTH-1:0];
                r_index  <= IDX_W'(1);
            end
            if (w_step) begin
                r_result <= w_sum;
                r_ovf    <= r_ovf | w_step_ovf;
                r_index  <= w_last ? '0 : r_index + 1'b1;
            end
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: directed operations checked against a signed
// arithmetic model every cycle, plus hand-computed literal expectations.
module tb_accum_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NOPS  = 4;

    logic                  clock;
    logic                  reset;
    logic                  start;
    logic [NOPS*WIDTH-1:0] ops;
    logic [NOPS-1:0]       sub_mask;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    int n_checks   = 0;
    int n_failures = 0;
    bit cmp_en     = 1'b1;

    // Model: cycles since capture (-1 = no operation in flight), shown values.
    int               m_age       = -1;
    logic [WIDTH-1:0] m_shown     = '0;
    logic             m_ovf_shown = 1'b0;
    logic [WIDTH-1:0] m_pend      = '0;
    logic             m_pend_ovf  = 1'b0;

    accum_sequencer #(
        .WIDTH (WIDTH),
        .NOPS  (NOPS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .ops      (ops),
        .sub_mask (sub_mask),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NOPS*WIDTH-1:0] mk(input logic [7:0] o0, input logic [7:0] o1,
                                                  input logic [7:0] o2, input logic [7:0] o3);
        return {o3, o2, o1, o0};
    endfunction

    // Signed left-to-right fold with true integer range checks.
    task automatic model_op(input logic [NOPS*WIDTH-1:0] o, input logic [NOPS-1:0] m,
                            output logic [WIDTH-1:0] res, output logic ov);
        int lim;
        int acc;
        int v;
        int t;
        lim = 1 << (WIDTH - 1);
        ov  = 1'b0;
        acc = int'(o[WIDTH-1:0]);
        if (acc >= lim) acc -= 2 * lim;
        for (int i = 1; i < NOPS; i++) begin
            v = int'(o[i*WIDTH +: WIDTH]);
            if (v >= lim) v -= 2 * lim;
            t = m[i] ? acc - v : acc + v;
            if (t >= lim || t < -lim) ov = 1'b1;
            if (t >= lim) t -= 2 * lim;
            if (t < -lim) t += 2 * lim;
            acc = t;
        end
        res = acc[WIDTH-1:0];
    endtask

    // Model update on each edge, from the rules of operation.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_age       = -1;
                m_shown     = '0;
                m_ovf_shown = 1'b0;
            end else if (m_age >= 0 && m_age < int'(NOPS)) begin
                m_age++;
                if (m_age == int'(NOPS)) begin
                    m_shown     = m_pend;
                    m_ovf_shown = m_pend_ovf;
                end
            end else if (start) begin
                m_age       = 0;
                m_ovf_shown = 1'b0;
                model_op(ops, sub_mask, m_pend, m_pend_ovf);
            end else begin
                m_age = -1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                check("busy", 32'(busy), 32'(m_age >= 0 && m_age < int'(NOPS)));
                check("done", 32'(done), 32'(m_age == int'(NOPS)));
                if (m_age <= 0 || m_age == int'(NOPS)) begin
                    check("result", 32'(result), 32'(m_shown));
                    check("ovf", 32'(ovf), 32'(m_ovf_shown));
                end
            end
        end
    end

    task automatic wait_done(inout int n);
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [NOPS*WIDTH-1:0] o, input logic [NOPS-1:0] m,
                          input logic [WIDTH-1:0] exp_res, input logic exp_ovf, input string nm);
        int n;
        @(negedge clock);
        ops      = o;
        sub_mask = m;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n     = 1;
        wait_done(n);
        check({nm, "_latency"}, 32'(n), 32'd5);
        check({nm, "_result"}, 32'(result), 32'(exp_res));
        check({nm, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        ops      = '0;
        sub_mask = '0;
        repeat (2) @(negedge clock);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;

        run_op(mk(8'd10, 8'd20, 8'd5, 8'd3), 4'b0000, 8'h26, 1'b0, "add_all");
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        run_op(mk(8'd10, 8'd20, 8'd5, 8'd3), 4'b1100, 8'd22, 1'b0, "mixed");
        run_op(mk(8'd100, 8'd100, 8'd0, 8'd0), 4'b0000, 8'hC8, 1'b1, "pos_ovf");
        run_op(mk(8'd1, 8'd2, 8'd3, 8'd4), 4'b0000, 8'd10, 1'b0, "ovf_clear");
        run_op(mk(8'h80, 8'd1, 8'd0, 8'd0), 4'b0010, 8'h7F, 1'b1, "neg_ovf");
        run_op(mk(8'd10, 8'd1, 8'd2, 8'd3), 4'b1111, 8'd4, 1'b0, "mask_bit0");
        run_op(mk(8'd5, 8'd10, 8'd0, 8'd0), 4'b0010, 8'hFB, 1'b0, "negative");

        repeat (3) @(negedge clock);
        check("hold_idle", 32'(result), 32'hFB);

        // start pulsed and operands changed while busy must not disturb the operation
        @(negedge clock);
        ops = mk(8'd1, 8'd1, 8'd1, 8'd1); sub_mask = 4'b0000; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; ops = mk(8'd50, 8'd50, 8'd50, 8'd50);
        @(negedge clock);
        start = 1'b0;
        n = 3;
        wait_done(n);
        check("ignore_start", 32'(result), 32'd4);

        // back-to-back with start held high; ops change during the first operation
        @(negedge clock);
        ops = mk(8'd10, 8'd20, 8'd5, 8'd3); sub_mask = 4'b0000; start = 1'b1;
        @(negedge clock);
        ops = mk(8'd1, 8'd2, 8'd3, 8'd4);
        n = 1;
        wait_done(n);
        check("b2b_first_lat", 32'(n), 32'd5);
        check("b2b_first", 32'(result), 32'd38);
        @(negedge clock);
        n = 1;
        wait_done(n);
        start = 1'b0;
        check("b2b_period", 32'(n), 32'd5);
        check("b2b_second", 32'(result), 32'd10);

        // reset in the middle of accumulation aborts at once
        @(negedge clock);
        ops = mk(8'd10, 8'd20, 8'd5, 8'd3); sub_mask = 4'b0000; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        run_op(mk(8'd1, 8'd2, 8'd3, 8'd4), 4'b0000, 8'd10, 1'b0, "after_reset");

        repeat (2) @(negedge clock);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
